// File: rtl/DataInterface_pkg.sv
// DataInterface_pkg: request structures exchanged between the disposition stage and the memory side.
package DataInterface_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WHO_W  = 8;

    typedef struct packed {
        logic              valid;
        logic [WHO_W-1:0]  who;
        logic [ADDR_W-1:0] address;
    } read_request_t;

    typedef struct packed {
        logic              valid;
        logic [WHO_W-1:0]  who;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } write_request_t;
endpackage

// File: rtl/Disposition_pkg.sv
// Disposition_pkg: slot codes, arbiter states, the buffered bundle and helpers that pick/format slots.
package Disposition_pkg;
    import DataInterface_pkg::*;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'b00,
        SLOT_R1   = 2'b01,
        SLOT_R2   = 2'b10,
        SLOT_W    = 2'b11
    } slot_e;

    typedef enum logic [1:0] {IDLE, ISSUE_R1, ISSUE_R2, ISSUE_W} state_e;

    typedef struct packed {
        read_request_t  r1;
        read_request_t  r2;
        write_request_t w;
    } bundle_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        slot_e             slot;
        logic [WHO_W-1:0]  who;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // First valid slot strictly after `from`; IDLE as `from` means start of the bundle.
    function automatic state_e first_slot(bundle_t b, state_e from);
        if (from == IDLE && b.r1.valid) return ISSUE_R1;
        if ((from == IDLE || from == ISSUE_R1) && b.r2.valid) return ISSUE_R2;
        if (from != ISSUE_W && b.w.valid) return ISSUE_W;
        return IDLE;
    endfunction

    function automatic mem_req_t make_req(bundle_t b, state_e s);
        mem_req_t r;
        r.valid   = s != IDLE;
        r.write   = s == ISSUE_W;
        r.slot    = s == ISSUE_R1 ? SLOT_R1 : s == ISSUE_R2 ? SLOT_R2 : s == ISSUE_W ? SLOT_W : SLOT_NONE;
        r.who     = s == ISSUE_R1 ? b.r1.who : s == ISSUE_R2 ? b.r2.who : s == ISSUE_W ? b.w.who : '0;
        r.address = s == ISSUE_R1 ? b.r1.address : s == ISSUE_R2 ? b.r2.address : s == ISSUE_W ? b.w.address : '0;
        r.data    = s == ISSUE_W ? b.w.data : '0;
        return r;
    endfunction
endpackage

// File: rtl/disposition_bundle_fifo.sv
// disposition_bundle_fifo: circular bundle buffer exposing the head and the entry behind it.
module disposition_bundle_fifo
    import Disposition_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  bundle_t din,
    output bundle_t head,
    output bundle_t nxt,
    output logic    full,
    output logic    empty,
    output logic    has_next
);
    localparam int PW = $clog2(DEPTH);

    bundle_t       mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q + PW'(pop);
        wr_d  = wr_q + PW'(push);
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign head     = mem_q[rd_q];
    assign nxt      = mem_q[rd_q + PW'(1)];
    assign full     = cnt_q == (PW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign has_next = cnt_q > (PW+1)'(1);
endmodule

// File: rtl/disposition_mem_arbiter.sv
// disposition_mem_arbiter: buffers request bundles and issues their valid slots to memory
// one at a time, reads before the write, with registered request outputs.
module disposition_mem_arbiter
    import DataInterface_pkg::*;
    import Disposition_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  read_request_t      read1,
    input  read_request_t      read2,
    input  write_request_t     write,
    output logic               stall,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_write,
    output logic [ADDR_W-1:0]  mem_req_address,
    output logic [DATA_W-1:0]  mem_req_data,
    output logic [ID_W+1:0]    mem_req_tag,
    output logic               overflow
);
    bundle_t  din, head, nxt, src;
    logic     any_valid, full, empty, has_next, push, pop, overflow_q, overflow_d;
    state_e   state_q, state_d;
    mem_req_t req_q, req_d;

    assign din       = '{r1: read1, r2: read2, w: write};
    assign any_valid = read1.valid | read2.valid | write.valid;
    assign push      = any_valid & ~full;

    disposition_bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (din),
        .head     (head),
        .nxt      (nxt),
        .full     (full),
        .empty    (empty),
        .has_next (has_next)
    );

    // The head stays in the FIFO until its last slot completes, so it is stable while issuing.
    always_comb begin
        state_d    = state_q;
        src        = head;
        pop        = 1'b0;
        overflow_d = overflow_q | (any_valid & full);
        if (state_q == IDLE) begin
            if (!empty) state_d = first_slot(head, IDLE);
        end else if (mem_req_ready) begin
            state_d = first_slot(head, state_q);
            if (state_d == IDLE) begin
                pop     = 1'b1;
                src     = nxt;
                state_d = has_next ? first_slot(nxt, IDLE) : IDLE;
            end
        end
        req_d = make_req(src, state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            overflow_q <= overflow_d;
        end
    end

    assign stall           = full;
    assign overflow        = overflow_q;
    assign mem_req_valid   = req_q.valid;
    assign mem_req_write   = req_q.write;
    assign mem_req_address = req_q.address;
    assign mem_req_data    = req_q.data;
    assign mem_req_tag     = {req_q.slot, ID_W'(req_q.who)};
endmodule

// File: tb/tb_disposition_mem_arbiter.sv
// tb_disposition_mem_arbiter: directed literal checks plus randomized traffic against a queue-based model.
module tb_disposition_mem_arbiter;
    import DataInterface_pkg::*;

    localparam int DEPTH = 2;
    localparam int ID_W  = 8;

    typedef struct packed {
        read_request_t  a;
        read_request_t  b;
        write_request_t c;
    } bund_t;

    typedef struct packed {
        logic        v;
        logic        wr;
        logic [31:0] ad;
        logic [31:0] dd;
        logic [9:0]  tg;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, ready = 1'b0;
    read_request_t  r1 = '0, r2 = '0;
    write_request_t w = '0;
    logic stall, v, wr, ovf;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [ID_W+1:0]   t;
    logic [77:0]       act;

    int n_cmp = 0, n_bad = 0;
    bund_t mq[$];
    int pos = 0;
    bit active = 0, movf = 0;

    always #5 clk = ~clk;

    disposition_mem_arbiter #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .read1           (r1),
        .read2           (r2),
        .write           (w),
        .stall           (stall),
        .mem_req_valid   (v),
        .mem_req_ready   (ready),
        .mem_req_write   (wr),
        .mem_req_address (a),
        .mem_req_data    (d),
        .mem_req_tag     (t),
        .overflow        (ovf)
    );

    assign act = {v, wr, a, d, t, stall, ovf};

    function automatic int nvalid(bund_t b);
        return int'(b.a.valid) + int'(b.b.valid) + int'(b.c.valid);
    endfunction

    // p-th valid request of a bundle, in the order read1, read2, write
    function automatic exp_t slot_req(bund_t b, int p);
        exp_t e = '0;
        int k = 0;
        if (b.a.valid) begin
            if (k == p) e = '{1'b1, 1'b0, b.a.address, 32'd0, {2'b01, b.a.who}};
            k++;
        end
        if (b.b.valid) begin
            if (k == p) e = '{1'b1, 1'b0, b.b.address, 32'd0, {2'b10, b.b.who}};
            k++;
        end
        if (b.c.valid && k == p) e = '{1'b1, 1'b1, b.c.address, b.c.data, {2'b11, b.c.who}};
        return e;
    endfunction

    function automatic logic [77:0] expv();
        exp_t e = active ? slot_req(mq[0], pos) : '0;
        return {e, mq.size() == DEPTH, movf};
    endfunction

    function automatic logic [77:0] lit(logic lv, logic lw, logic [31:0] ad, logic [31:0] dd,
                                        logic [9:0] tg, logic st, logic ov);
        return {lv, lw, ad, dd, tg, st, ov};
    endfunction

    task automatic model_edge();
        int n = mq.size();
        if (rst) begin
            mq.delete();
            active = 0;
            pos = 0;
            movf = 0;
            return;
        end
        if (active && ready) begin
            pos++;
            if (pos == nvalid(mq[0])) begin
                void'(mq.pop_front());
                pos = 0;
                active = mq.size() > 0;
            end
        end else if (!active && n > 0) active = 1;
        if (r1.valid | r2.valid | w.valid) begin
            if (n == DEPTH) movf = 1;
            else mq.push_back('{r1, r2, w});
        end
    endtask

    task automatic chk(string name, logic [77:0] got, logic [77:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", act, expv());
    endtask

    task automatic idle();
        r1 = '0;
        r2 = '0;
        w  = '0;
    endtask

    task automatic full_bundle();
        r1 = '{valid: 1'b1, who: 8'd1, address: 32'd8};
        r2 = '{valid: 1'b1, who: 8'd2, address: 32'd9};
        w  = '{valid: 1'b1, who: 8'd3, address: 32'd10, data: 32'd87};
    endtask

    initial begin
        int cnt;
        logic [77:0] z, e_r1, e_r2, e_w;
        z    = '0;
        e_r1 = lit(1'b1, 1'b0, 32'd8, 32'd0, {2'b01, 8'd1}, 1'b0, 1'b0);
        e_r2 = lit(1'b1, 1'b0, 32'd9, 32'd0, {2'b10, 8'd2}, 1'b0, 1'b0);
        e_w  = lit(1'b1, 1'b1, 32'd10, 32'd87, {2'b11, 8'd3}, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("reset_zero", act, z);
        rst = 1'b0;

        ready = 1'b1;
        r1 = '{valid: 1'b1, who: 8'd54, address: 32'd8};
        cyc();
        chk("single_latency", act, z);
        idle();
        cyc();
        chk("single_req", act, lit(1'b1, 1'b0, 32'd8, 32'd0, 10'h136, 1'b0, 1'b0));
        cyc();
        chk("single_idle", act, z);

        full_bundle();
        cyc();
        idle();
        cyc();
        chk("order_r1", act, e_r1);
        cyc();
        chk("order_r2", act, e_r2);
        cyc();
        chk("order_w", act, e_w);
        cyc();
        chk("order_idle", act, z);

        ready = 1'b0;
        full_bundle();
        cyc();
        idle();
        cyc();
        chk("hold_r1_0", act, e_r1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk($sformatf("hold_r1_%0d", i), act, e_r1);
        end
        ready = 1'b1;
        cyc();
        chk("hold_r2", act, e_r2);
        cyc();
        chk("hold_w", act, e_w);
        cyc();
        chk("hold_idle", act, z);

        ready = 1'b0;
        r1 = '{valid: 1'b1, who: 8'd5, address: 32'd1};
        cyc();
        chk("ovf_stall_lo", {77'd0, act[1]}, 78'd0);
        r1.address = 32'd2;
        cyc();
        chk("ovf_stall_hi", {77'd0, act[1]}, 78'd1);
        r1.address = 32'd3;
        cyc();
        chk("ovf_flag", {77'd0, act[0]}, 78'd1);
        idle();
        ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (v) cnt++;
            cyc();
        end
        chk("ovf_issued", 78'(cnt), 78'd2);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ready = 1'b0;
        full_bundle();
        cyc();
        idle();
        cyc();
        ready = 1'b1;
        cyc();
        chk("rst_in_r2_pre", act, e_r2);
        rst = 1'b1;
        cyc();
        chk("rst_in_r2", act, z);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            r1 = '{valid: $urandom_range(0, 2) == 0, who: 8'($urandom), address: $urandom};
            r2 = '{valid: $urandom_range(0, 2) == 0, who: 8'($urandom), address: $urandom};
            w  = '{valid: $urandom_range(0, 2) == 0, who: 8'($urandom), address: $urandom, data: $urandom};
            ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 299) == 0;
            cyc();
        end
        rst = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
